// File: rtl/gcd_pkg.sv
// Shared types and sizing helpers for the GCD requester.
package gcd_pkg;

   localparam int unsigned NBITS_DEFAULT = 8;
   localparam int unsigned DONE_CNT_W    = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      RESP
   } req_state_t;

   // Timeout counter width; never narrower than one bit.
   function automatic int unsigned tw(input int unsigned timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/gcd_timeout_counter.sv
// WAIT-cycle watchdog: counts enabled cycles and flags expiry after the
// cycle in which the count sits at its terminal value TIMEOUT-1.
module gcd_timeout_counter
   import gcd_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned TW = tw(TIMEOUT);

   logic [TW-1:0] count;
   logic          at_term;

   assign at_term = (count == TW'(TIMEOUT - 1));

   // Count saturates at the terminal value; expiry is registered from it.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count   <= '0;
         expired <= 1'b0;
      end else if (en) begin
         if (!at_term) begin
            count <= count + TW'(1);
         end
         expired <= at_term;
      end
   end

endmodule

// File: rtl/gcd_requester.sv
// Initiator-side sequencer: hands one operand pair at a time to a GCD engine
// and returns its result (or a timeout abort) on a valid/ready stream.
module gcd_requester
   import gcd_pkg::*;
#(
   parameter int unsigned NBits   = NBITS_DEFAULT,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NBits-1:0]      in_x,
   input  logic [NBits-1:0]      in_y,
   output logic [NBits-1:0]      eng_xi,
   output logic [NBits-1:0]      eng_yi,
   output logic                  eng_start,
   input  logic                  eng_rdy,
   input  logic [NBits-1:0]      eng_xo,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [NBits-1:0]      out_gcd,
   output logic                  out_err,
   output logic                  busy,
   output logic [DONE_CNT_W-1:0] done_count
);

   req_state_t              state, state_nx;
   logic [NBits-1:0]        x_q, y_q, x_nx, y_nx;
   logic [NBits-1:0]        gcd_nx;
   logic                    err_nx;
   logic [DONE_CNT_W-1:0]   done_nx;
   logic                    expired;

   gcd_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == START),
      .en      (state == WAIT),
      .expired (expired)
   );

   // Handshake flags decode straight from state; in_ready is masked by reset.
   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == RESP);
   assign busy      = (state != IDLE);
   assign eng_xi    = x_q;
   assign eng_yi    = y_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         eng_start  <= 1'b0;
         out_gcd    <= '0;
         out_err    <= 1'b0;
         done_count <= '0;
      end else begin
         state      <= state_nx;
         x_q        <= x_nx;
         y_q        <= y_nx;
         eng_start  <= (state_nx == START);
         out_gcd    <= gcd_nx;
         out_err    <= err_nx;
         done_count <= done_nx;
      end
   end

   // Engine rdy/xo are only looked at in WAIT, so stale completions are ignored.
   always_comb begin
      state_nx = state;
      x_nx     = x_q;
      y_nx     = y_q;
      gcd_nx   = out_gcd;
      err_nx   = out_err;
      done_nx  = done_count;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               x_nx     = in_x;
               y_nx     = in_y;
               state_nx = LOAD;
            end
         end
         LOAD:  state_nx = START;
         START: state_nx = WAIT;
         WAIT: begin
            if (eng_rdy) begin
               gcd_nx   = eng_xo;
               err_nx   = 1'b0;
               state_nx = RESP;
            end else if (expired) begin
               gcd_nx   = '0;
               err_nx   = 1'b1;
               state_nx = RESP;
            end
         end
         RESP: begin
            if (out_ready) begin
               state_nx = IDLE;
               if (!out_err) begin
                  done_nx = done_count + DONE_CNT_W'(1);
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_gcd_requester.sv
// Self-checking bench for gcd_requester with a behavioural GCD engine model.
module tb_gcd_requester;

   localparam int unsigned NB = 8;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [NB-1:0] in_x = '0, in_y = '0;
   logic [NB-1:0] eng_xi, eng_yi, eng_xo;
   logic          eng_start, eng_rdy;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [NB-1:0] out_gcd;
   logic          out_err, busy;
   logic [15:0]   done_count;

   int checks = 0;
   int errors = 0;
   int exp_done = 0;

   gcd_requester #(.NBits(NB), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
      .eng_xi(eng_xi), .eng_yi(eng_yi), .eng_start(eng_start),
      .eng_rdy(eng_rdy), .eng_xo(eng_xo),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_gcd(out_gcd), .out_err(out_err),
      .busy(busy), .done_count(done_count)
   );

   always #5 clk = ~clk;

   function automatic logic [NB-1:0] ref_gcd(input logic [NB-1:0] a, input logic [NB-1:0] b);
      int unsigned p = a, q = b, t;
      if (a == 0 || b == 0) return '0;
      while (q != 0) begin
         t = p % q;
         p = q;
         q = t;
      end
      return NB'(p);
   endfunction

   // Engine model: latches operands on start, answers after eng_delay cycles.
   logic          m_rdy = 1'b0, m_run = 1'b0;
   logic [NB-1:0] m_xo = '0, m_a = '0, m_b = '0;
   int            m_cnt = 0;
   int            eng_delay = 0;
   bit            stuck = 1'b0;
   logic          rdy_pulse = 1'b0;

   assign eng_rdy = m_rdy | rdy_pulse;
   assign eng_xo  = rdy_pulse ? 8'hA5 : m_xo;

   always @(posedge clk) begin
      if (eng_start) begin
         m_run <= 1'b1;
         m_rdy <= 1'b0;
         m_cnt <= eng_delay;
         m_a   <= eng_xi;
         m_b   <= eng_yi;
      end else if (m_run && !stuck) begin
         if (m_cnt == 0) begin
            m_rdy <= 1'b1;
            m_xo  <= ref_gcd(m_a, m_b);
            m_run <= 1'b0;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   task automatic send(input logic [NB-1:0] x, input logic [NB-1:0] y, output logic acc);
      @(negedge clk);
      acc      = in_ready;
      in_x     = x;
      in_y     = y;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Cycle 1 is the first cycle after the accept edge.
   task automatic wait_out(input logic [NB-1:0] x, input logic [NB-1:0] y, input int pulse_cyc,
                           output int lat, output int nstart, output int start_cyc, output bit opnd_ok);
      lat = -1; nstart = 0; start_cyc = -1; opnd_ok = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         rdy_pulse = (c == pulse_cyc);
         if (eng_start) begin
            nstart++;
            if (start_cyc < 0) start_cyc = c;
         end
         if (out_valid) begin
            lat = c;
            break;
         end
         if (eng_xi !== x || eng_yi !== y) opnd_ok = 1'b0;
      end
      rdy_pulse = 1'b0;
   endtask

   task automatic recv();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      checks++; if ({out_valid, busy, eng_start, out_err} !== 4'b0) begin errors++;
         $display("FAIL reset_flags got %b want 0000", {out_valid, busy, eng_start, out_err}); end
      checks++; if ({eng_xi, eng_yi, out_gcd} !== 24'h0) begin errors++;
         $display("FAIL reset_data got %h want 000000", {eng_xi, eng_yi, out_gcd}); end
      checks++; if (done_count !== 16'd0) begin errors++; $display("FAIL reset_done got %0d want 0", done_count); end
      rst = 1'b0;
      exp_done = 0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_basic();
      logic acc; int lat, ns, sc; bit ok;
      eng_delay = 3;
      send(8'd12, 8'd18, acc);
      wait_out(8'd12, 8'd18, 0, lat, ns, sc, ok);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL basic_accept got %b want 1", acc); end
      checks++; if (ns != 1 || sc != 2) begin errors++; $display("FAIL basic_start got count=%0d cycle=%0d want 1/2", ns, sc); end
      checks++; if (lat != 3 + 5) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, 8); end
      checks++; if (!ok) begin errors++; $display("FAIL basic_operands got unstable eng_xi/eng_yi want 12/18"); end
      checks++; if (out_gcd !== 8'd6 || out_err !== 1'b0) begin errors++;
         $display("FAIL basic_result got %0d err=%b want 6 err=0", out_gcd, out_err); end
      recv(); exp_done++;
      @(negedge clk);
      checks++; if (done_count !== 16'(exp_done)) begin errors++; $display("FAIL basic_done got %0d want %0d", done_count, exp_done); end
   endtask

   task automatic test_equal_zero();
      logic acc; int lat, ns, sc; bit ok;
      logic [NB-1:0] xs[2] = '{8'd7, 8'd0};
      logic [NB-1:0] ys[2] = '{8'd7, 8'd5};
      logic [NB-1:0] es[2] = '{8'd7, 8'd0};
      eng_delay = 1;
      for (int i = 0; i < 2; i++) begin
         send(xs[i], ys[i], acc);
         wait_out(xs[i], ys[i], 0, lat, ns, sc, ok);
         checks++; if (lat < 0 || out_gcd !== es[i] || out_err !== 1'b0) begin errors++;
            $display("FAIL eqzero_%0d got lat=%0d gcd=%0d err=%b want gcd=%0d err=0", i, lat, out_gcd, out_err, es[i]); end
         recv(); exp_done++;
      end
      @(negedge clk);
      checks++; if (done_count !== 16'(exp_done)) begin errors++; $display("FAIL eqzero_done got %0d want %0d", done_count, exp_done); end
   endtask

   task automatic test_timeout();
      logic acc; int lat, ns, sc; bit ok;
      stuck = 1'b1;
      send(8'd5, 8'd10, acc);
      wait_out(8'd5, 8'd10, 0, lat, ns, sc, ok);
      checks++; if (lat != TO + 4) begin errors++; $display("FAIL timeout_latency got %0d want %0d", lat, TO + 4); end
      checks++; if (out_gcd !== 8'd0 || out_err !== 1'b1) begin errors++;
         $display("FAIL timeout_result got %0d err=%b want 0 err=1", out_gcd, out_err); end
      checks++; if (!ok) begin errors++; $display("FAIL timeout_operands got unstable eng_xi/eng_yi want 5/10"); end
      recv();
      @(negedge clk);
      checks++; if (done_count !== 16'(exp_done)) begin errors++; $display("FAIL timeout_done got %0d want %0d", done_count, exp_done); end
      stuck = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic acc; int lat, ns, sc; bit ok; bit stable = 1'b1;
      eng_delay = 2;
      send(8'd48, 8'd36, acc);
      wait_out(8'd48, 8'd36, 0, lat, ns, sc, ok);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_gcd !== 8'd12 || out_err !== 1'b0 || in_ready !== 1'b0) stable = 1'b0;
      end
      checks++; if (!stable || lat < 0) begin errors++;
         $display("FAIL backpressure_hold got valid=%b gcd=%0d in_ready=%b want 1/12/0", out_valid, out_gcd, in_ready); end
      recv(); exp_done++;
      send(8'd9, 8'd6, acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b want 1", acc); end
      wait_out(8'd9, 8'd6, 0, lat, ns, sc, ok);
      checks++; if (out_gcd !== 8'd3 || out_err !== 1'b0) begin errors++;
         $display("FAIL b2b_result got %0d err=%b want 3 err=0", out_gcd, out_err); end
      recv(); exp_done++;
      @(negedge clk);
      checks++; if (done_count !== 16'(exp_done)) begin errors++; $display("FAIL b2b_done got %0d want %0d", done_count, exp_done); end
   endtask

   task automatic test_stale_rdy();
      logic acc; int lat, ns, sc; bit ok;
      eng_delay = 2;
      send(8'd20, 8'd15, acc);
      wait_out(8'd20, 8'd15, 1, lat, ns, sc, ok);
      checks++; if (lat != 2 + 5 || out_gcd !== 8'd5 || out_err !== 1'b0) begin errors++;
         $display("FAIL stale_rdy got lat=%0d gcd=%0d err=%b want 7/5/0", lat, out_gcd, out_err); end
      recv(); exp_done++;
   endtask

   task automatic test_random();
      logic acc; int lat, ns, sc; bit ok;
      logic [NB-1:0] x, y, e;
      int bp, bad;
      bad = 0;
      for (int n = 0; n < 30; n++) begin
         x = NB'($urandom_range(0, 255));
         y = NB'($urandom_range(1, 255));
         if ($urandom_range(0, 7) == 0) x = '0;
         e = ref_gcd(x, y);
         eng_delay = $urandom_range(0, 6);
         bp = $urandom_range(0, 3);
         send(x, y, acc);
         wait_out(x, y, 0, lat, ns, sc, ok);
         repeat (bp) @(negedge clk);
         checks++;
         if (acc !== 1'b1 || lat != eng_delay + 5 || !ok || ns != 1 || out_gcd !== e || out_err !== 1'b0) begin
            errors++;
            $display("FAIL random_%0d x=%0d y=%0d got gcd=%0d err=%b lat=%0d want gcd=%0d err=0 lat=%0d",
                     n, x, y, out_gcd, out_err, lat, e, eng_delay + 5);
         end
         recv(); exp_done++;
      end
      @(negedge clk);
      checks++; if (done_count !== 16'(exp_done)) begin errors++; $display("FAIL random_done got %0d want %0d", done_count, exp_done); end
   endtask

   task automatic test_reset_mid();
      logic acc; bit seen = 1'b0;
      stuck = 1'b1;
      send(8'd30, 8'd12, acc);
      repeat (6) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b want 1", busy); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy, eng_start, out_err} !== 5'b0 || {eng_xi, eng_yi, out_gcd} !== 24'h0 || done_count !== 16'd0) begin
         errors++;
         $display("FAIL midrst_values got flags=%b data=%h done=%0d want 0/0/0",
                  {in_ready, out_valid, busy, eng_start, out_err}, {eng_xi, eng_yi, out_gcd}, done_count);
      end
      rst = 1'b0; exp_done = 0; stuck = 1'b0;
      repeat (TO + 8) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checks++; if (seen || in_ready !== 1'b1) begin errors++;
         $display("FAIL midrst_drop got out_valid_seen=%b in_ready=%b want 0/1", seen, in_ready); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_equal_zero();
      test_timeout();
      test_back_to_back();
      test_stale_rdy();
      test_random();
      test_reset_mid();
      test_basic();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
